// File: rtl/osc_measure_sequencer.sv
// OPB bus-master sequencer for one oscillator-frequency measurement:
// load divider, clear, start, poll, read count, then judge against limits.
module osc_measure_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  output logic [1:0]  OPB_ADDR,
  output logic [31:0] OPB_WDATA,
  input  logic [31:0] OPB_RDATA,
  output logic        OPB_RE,
  output logic        OPB_WE,
  input  logic        MEAS_START,
  input  logic        MEAS_ABORT,
  input  logic [15:0] MEAS_DIV,
  input  logic [15:0] LIMIT_LO,
  input  logic [15:0] LIMIT_HI,
  output logic        MEAS_BUSY,
  output logic        MEAS_DONE,
  output logic [15:0] MEAS_COUNT,
  output logic        MEAS_PASS,
  output logic        MEAS_FAIL,
  output logic        MEAS_TIMEOUT
);

  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_CLR, POLL_CLR, WR_GO,
    POLL_RUN, RD_CNT, CHECK, DONE, ABORT_CLR
  } state_t;

  state_t      state;
  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic [15:0] rd_q;
  logic [23:0] tmo_cnt;
  logic        rej_q;
  logic        tmo_hit;

  logic acc;
  logic tmo_exp;
  logic in_rng;
  logic unused_rdata;

  // acc: an access is on the bus this cycle, so the next one must idle
  assign acc     = OPB_RE | OPB_WE;
  assign tmo_exp = (tmo_cnt == TIMEOUT_CYCLES);
  assign in_rng  = (rd_q >= lo_q) && (rd_q <= hi_q);
  assign unused_rdata = ^OPB_RDATA[31:16];

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state        <= IDLE;
      OPB_ADDR     <= '0;
      OPB_WDATA    <= '0;
      OPB_RE       <= 1'b0;
      OPB_WE       <= 1'b0;
      MEAS_BUSY    <= 1'b0;
      MEAS_DONE    <= 1'b0;
      MEAS_COUNT   <= '0;
      MEAS_PASS    <= 1'b0;
      MEAS_FAIL    <= 1'b0;
      MEAS_TIMEOUT <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      rd_q         <= '0;
      tmo_cnt      <= '0;
      rej_q        <= 1'b0;
      tmo_hit      <= 1'b0;
    end else begin
      OPB_RE    <= 1'b0;
      OPB_WE    <= 1'b0;
      OPB_ADDR  <= 2'd0;
      OPB_WDATA <= 32'h0;
      MEAS_DONE <= 1'b0;
      if (state != IDLE && state != ABORT_CLR && MEAS_ABORT) begin
        state   <= ABORT_CLR;
        tmo_hit <= 1'b0;
        if (!acc) begin
          OPB_WE    <= 1'b1;
          OPB_WDATA <= 32'h2;
        end
      end else begin
        case (state)
          IDLE: begin
            if (MEAS_START && !MEAS_ABORT) begin
              lo_q         <= LIMIT_LO;
              hi_q         <= LIMIT_HI;
              MEAS_PASS    <= 1'b0;
              MEAS_FAIL    <= 1'b0;
              MEAS_TIMEOUT <= 1'b0;
              MEAS_BUSY    <= 1'b1;
              tmo_hit      <= 1'b0;
              rej_q        <= (MEAS_DIV == 16'd0);
              if (MEAS_DIV == 16'd0) begin
                state <= CHECK;
              end else begin
                state     <= WR_DIV;
                OPB_WE    <= 1'b1;
                OPB_ADDR  <= 2'd1;
                OPB_WDATA <= {16'h0, MEAS_DIV};
              end
            end
          end
          WR_DIV: state <= WR_CLR;
          WR_CLR: begin
            if (acc) begin
              state   <= POLL_CLR;
              tmo_cnt <= '0;
            end else begin
              OPB_WE    <= 1'b1;
              OPB_WDATA <= 32'h2;
            end
          end
          POLL_CLR: begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (tmo_exp) begin
              state   <= ABORT_CLR;
              tmo_hit <= 1'b1;
              if (!acc) begin
                OPB_WE    <= 1'b1;
                OPB_WDATA <= 32'h2;
              end
            end else if (acc) begin
              if (!OPB_RDATA[1]) state <= WR_GO;
            end else begin
              OPB_RE <= 1'b1;
            end
          end
          WR_GO: begin
            if (acc) begin
              state   <= POLL_RUN;
              tmo_cnt <= '0;
            end else begin
              OPB_WE    <= 1'b1;
              OPB_WDATA <= 32'h1;
            end
          end
          POLL_RUN: begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (tmo_exp) begin
              state   <= ABORT_CLR;
              tmo_hit <= 1'b1;
              if (!acc) begin
                OPB_WE    <= 1'b1;
                OPB_WDATA <= 32'h2;
              end
            end else if (acc) begin
              if (!OPB_RDATA[2]) state <= RD_CNT;
            end else begin
              OPB_RE <= 1'b1;
            end
          end
          RD_CNT: begin
            if (acc) begin
              rd_q  <= OPB_RDATA[15:0];
              state <= CHECK;
            end else begin
              OPB_RE   <= 1'b1;
              OPB_ADDR <= 2'd2;
            end
          end
          CHECK: begin
            MEAS_DONE <= 1'b1;
            state     <= DONE;
            if (tmo_hit) begin
              MEAS_TIMEOUT <= 1'b1;
              MEAS_FAIL    <= 1'b1;
              MEAS_COUNT   <= '0;
            end else if (rej_q) begin
              MEAS_FAIL  <= 1'b1;
              MEAS_COUNT <= '0;
            end else begin
              MEAS_COUNT <= rd_q;
              MEAS_PASS  <= in_rng;
              MEAS_FAIL  <= !in_rng;
            end
          end
          DONE: begin
            state     <= IDLE;
            MEAS_BUSY <= 1'b0;
          end
          ABORT_CLR: begin
            if (acc) begin
              if (tmo_hit) begin
                state <= CHECK;
              end else begin
                state     <= IDLE;
                MEAS_BUSY <= 1'b0;
              end
            end else begin
              OPB_WE    <= 1'b1;
              OPB_WDATA <= 32'h2;
            end
          end
          default: begin
            state     <= IDLE;
            MEAS_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
